aclk_keypad_scanner: RTL and testbench
======================================

# aclk_keypad_scanner

Matrix-keypad front end for the alarm clock: scans a 4-row x 3-column keypad, synchronises and debounces the column returns, and produces the 4-bit `key` code that the controller and key register consume. It is the producing end of the `key` interface; the clock top instantiates it between the keypad pins and its `key` input. Digits 0-9 are encoded as 4'd0-4'd9; no valid press is encoded as 4'd10 (NOKEY).

## Interface
- SCAN_DIV, 16: clock cycles each row is driven before its columns are sampled (>= 4).
- DEBOUNCE_SCANS, 4: consecutive identical samples needed to accept a press or a release (>= 2).
- clk  input  1  system clock (same clock as the rest of the alarm clock).
- reset  input  1  asynchronous, active-low reset.
- col  input  3  keypad column returns, active-low (external pull-ups); asynchronous to clk.
- row  output  4  keypad row drives, active-low, exactly one bit low at all times.
- key  output  4  debounced key code: 0-9 while a digit is held, 10 otherwise.
- key_strobe  output  1  one-cycle pulse on the cycle `key` changes from 10 to a digit.

## Operation
- Keymap (row, col): r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = *,0,#. `*` and `#` are not digits and always read as "no press".
- `col` passes through a 2-flop synchroniser; all decisions use the synchronised value.
- Dwell counter counts 0..SCAN_DIV-1 and wraps; a **sample** happens on the cycle it equals SCAN_DIV-1. A sample is **valid** when exactly one synchronised column is low and the (row,col) is a digit; otherwise it is "none". Two or more columns low reads as "none".
- States:
  - SCAN: at each sample, if valid, capture code, hold current row, match count = 1, go DEBOUNCE. Otherwise advance row r0->r1->r2->r3->r0.
  - DEBOUNCE: row held. At each sample, if the code equals the captured code, increment the match count. When it reaches DEBOUNCE_SCANS, go HELD, load `key` with the code, and pulse `key_strobe`. Any mismatch or "none" returns to SCAN with the row advanced; `key` stays 10.
  - HELD: row held. At each sample, "none" increments the release count and a sample equal to the held code clears it. A different valid digit also counts as "none". When the release count reaches DEBOUNCE_SCANS, set `key` = 10, go SCAN, and advance the row.
- Only one key is reported at a time. A second key pressed while in HELD is ignored until the first key is released.
- `key` changes only on HELD entry and exit. `key_strobe` fires once per accepted press; holding a key does not auto-repeat.

## Timing
- Reset values: row = 4'b1110, key = 4'd10, key_strobe = 0, state SCAN, dwell/match/release counters 0, synchroniser flops all 1.
- Reset asserted mid-operation returns everything to the reset values asynchronously. No strobe is emitted on reset release.
- Row change takes effect the cycle after a sample; columns then get SCAN_DIV-1 cycles to settle and synchronise before the next sample.
- Press latency, measured from the first sample that sees a stable press to `key` valid: (DEBOUNCE_SCANS-1)*SCAN_DIV + 1 cycles. `key` and `key_strobe` are registered and update together.
- Worst-case press latency adds a full scan rotation (4*SCAN_DIV) plus 2 synchroniser cycles.
- Release latency, from the first "none" sample to `key` = 10: (DEBOUNCE_SCANS-1)*SCAN_DIV + 1 cycles.
- Counter widths: dwell is $clog2(SCAN_DIV) bits; match and release are $clog2(DEBOUNCE_SCANS+1) bits. Counters saturate and never wrap inside a state.

## Test plan
- Reset, no keys (col = 3'b111) for 10 rotations -> row cycles 1110,1101,1011,0111 every 16 clk; key stays 10; key_strobe never 1.
- Hold "5" (col[1] low while row[1] low) stably -> key = 5 exactly 3*16+1 cycles after the first valid sample; one key_strobe; row frozen at 1101 while held.
- Release "5" -> key = 10 exactly 49 cycles after the first "none" sample; scanning resumes at row 1011.
- Bounce "8": 3 valid samples then 1 "none", then stable -> no strobe from the first burst; the stable press later yields key = 8 with a single strobe.
- Press "*" or "#", or press "1" and "2" together (two columns low) -> key stays 10, no strobe, scanning continues.
- Hold "0", press "3" meanwhile, release "0" while keeping "3" -> key = 0 then 10 after the release debounce, then key = 3 with a new strobe. Asserting reset while "0" is held -> key = 10 and row = 1110 immediately.

Source files
------------

// File: rtl/aclk_keypad_scanner.sv
// aclk_keypad_scanner
// Scans a 4x3 matrix keypad one row at a time, synchronises the active-low
// column returns, debounces presses and releases, and presents the held digit
// as a 4-bit key code (10 = no key) with a one-cycle strobe on each new press.

module aclk_keypad_scanner #(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] col,
    output logic [3:0] row,
    output logic [3:0] key,
    output logic       key_strobe
);

    localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_SCANS - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [3:0]         NOKEY      = 4'd10;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t state;
    state_t next_state;

    logic [2:0]         col_meta;
    logic [2:0]         col_sync;
    logic [DWELL_W-1:0] dwell;
    logic               sample;
    logic [1:0]         row_idx;
    logic [CNT_W-1:0]   match_cnt;
    logic [CNT_W-1:0]   rel_cnt;
    logic [3:0]         cap_code;

    logic               col_hit;
    logic [1:0]         col_num;
    logic [3:0]         samp_code;
    logic               samp_valid;
    logic               same_cap;
    logic               same_held;

    logic               advance_row;
    logic               capture;
    logic               match_inc;
    logic               key_load;
    logic               key_clear;
    logic               rel_inc;
    logic               rel_clr;

    // Two-flop synchroniser for the asynchronous column returns (idle = pulled high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_meta <= 3'b111;
            col_sync <= 3'b111;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    // Free-running dwell counter; its last count marks the column sample point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell <= '0;
        end else if (sample) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    assign sample = (dwell == DWELL_LAST);

    // Identify which single column is pulled low; zero or several low means no hit.
    always_comb begin
        col_hit = 1'b1;
        col_num = 2'd0;
        case (~col_sync)
            3'b001:  col_num = 2'd0;
            3'b010:  col_num = 2'd1;
            3'b100:  col_num = 2'd2;
            default: col_hit = 1'b0;
        endcase
    end

    // Map (row, column) to a digit code; * and # are treated as no press.
    always_comb begin
        samp_code = NOKEY;
        if (col_hit) begin
            case (row_idx)
                2'd0: samp_code = 4'd1 + {2'b00, col_num};
                2'd1: samp_code = 4'd4 + {2'b00, col_num};
                2'd2: samp_code = 4'd7 + {2'b00, col_num};
                default: begin
                    if (col_num == 2'd1) begin
                        samp_code = 4'd0;
                    end
                end
            endcase
        end
        samp_valid = (samp_code != NOKEY);
        same_cap   = samp_valid && (samp_code == cap_code);
        same_held  = samp_valid && (samp_code == key);
    end

    // Scanner state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SCAN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decision, taken only at sample points.
    always_comb begin
        next_state = state;
        case (state)
            SCAN: begin
                if (sample && samp_valid) begin
                    next_state = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (!same_cap) begin
                        next_state = SCAN;
                    end else if (match_cnt >= CNT_LAST) begin
                        next_state = HELD;
                    end
                end
            end
            HELD: begin
                if (sample && !same_held && (rel_cnt >= CNT_LAST)) begin
                    next_state = SCAN;
                end
            end
            default: next_state = SCAN;
        endcase
    end

    // Datapath controls derived from the current state and the sample result.
    always_comb begin
        advance_row = 1'b0;
        capture     = 1'b0;
        match_inc   = 1'b0;
        key_load    = 1'b0;
        key_clear   = 1'b0;
        rel_inc     = 1'b0;
        rel_clr     = 1'b0;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (samp_valid) begin
                        capture = 1'b1;
                    end else begin
                        advance_row = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!same_cap) begin
                        advance_row = 1'b1;
                    end else if (match_cnt >= CNT_LAST) begin
                        key_load = 1'b1;
                    end else begin
                        match_inc = 1'b1;
                    end
                end
                HELD: begin
                    if (same_held) begin
                        rel_clr = 1'b1;
                    end else if (rel_cnt >= CNT_LAST) begin
                        key_clear   = 1'b1;
                        advance_row = 1'b1;
                    end else begin
                        rel_inc = 1'b1;
                    end
                end
                default: begin
                    advance_row = 1'b0;
                end
            endcase
        end
    end

    // Row pointer only moves while scanning or when a press attempt is abandoned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_idx <= 2'd0;
        end else if (advance_row) begin
            row_idx <= row_idx + 2'd1;
        end
    end

    // Drive exactly one row low.
    always_comb begin
        row          = 4'b1111;
        row[row_idx] = 1'b0;
    end

    // Captured code and saturating press-match counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_code  <= NOKEY;
            match_cnt <= '0;
        end else begin
            if (capture) begin
                cap_code  <= samp_code;
                match_cnt <= CNT_W'(1);
            end else if (match_inc) begin
                if (match_cnt < CNT_FULL) begin
                    match_cnt <= match_cnt + 1'b1;
                end
            end else if (key_load || advance_row) begin
                match_cnt <= '0;
            end
        end
    end

    // Saturating release counter, cleared whenever the held key is seen again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rel_cnt <= '0;
        end else if (rel_clr || key_load || key_clear) begin
            rel_cnt <= '0;
        end else if (rel_inc && (rel_cnt < CNT_FULL)) begin
            rel_cnt <= rel_cnt + 1'b1;
        end
    end

    // Registered key code and strobe change together on HELD entry and exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key        <= NOKEY;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= key_load;
            if (key_load) begin
                key <= cap_code;
            end else if (key_clear) begin
                key <= NOKEY;
            end
        end
    end

endmodule

// File: tb/tb_aclk_keypad_scanner.sv
// tb_aclk_keypad_scanner
// Directed keypad scenarios with a scoreboard: every expected key change or
// strobe is queued with the clock edge it must appear on, and a monitor pops
// and compares whenever the scanner's key or key_strobe moves.

module tb_aclk_keypad_scanner;

    localparam int K1    = 0;
    localparam int K3    = 2;
    localparam int K2    = 1;
    localparam int K5    = 4;
    localparam int K8    = 7;
    localparam int KSTAR = 9;
    localparam int K0    = 10;
    localparam int KHASH = 11;

    typedef struct {
        logic [3:0] key;
        logic       strobe;
        int         at_edge;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  col;
    logic [3:0]  row;
    logic [3:0]  key;
    logic        key_strobe;
    logic [11:0] pressed = '0;

    int          edge_cnt;
    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    exp_t        got;
    logic [3:0]  prev_key;
    logic [3:0]  exp_row;

    aclk_keypad_scanner #(
        .SCAN_DIV       (16),
        .DEBOUNCE_SCANS (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .col        (col),
        .row        (row),
        .key        (key),
        .key_strobe (key_strobe)
    );

    always #5 clk = ~clk;

    // Keypad matrix model: a pressed key pulls its column low while its row is driven.
    assign col[0] = ~|({pressed[9],  pressed[6], pressed[3], pressed[0]} & ~row);
    assign col[1] = ~|({pressed[10], pressed[7], pressed[4], pressed[1]} & ~row);
    assign col[2] = ~|({pressed[11], pressed[8], pressed[5], pressed[2]} & ~row);

    // Posedges since the last reset release; edge N is the Nth rising edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    // Monitor: any key change or strobe is matched against the next queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            prev_key = key;
        end else if (key !== prev_key || key_strobe !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_event: key=%0d strobe=%0b at edge %0d, no event expected",
                         key, key_strobe, edge_cnt);
            end else begin
                got = exp_q.pop_front();
                if (key !== got.key || key_strobe !== got.strobe || edge_cnt != got.at_edge) begin
                    errors++;
                    $display("[TB] FAIL key_event: got key=%0d strobe=%0b edge=%0d, expected key=%0d strobe=%0b edge=%0d",
                             key, key_strobe, edge_cnt, got.key, got.strobe, got.at_edge);
                end
            end
            prev_key = key;
        end
    end

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at edge %0d", name, actual, expected, edge_cnt);
        end
    endtask

    task automatic goTo(input int n);
        while (edge_cnt < n) @(negedge clk);
    endtask

    task automatic applyStimulus(input int at_edge, input int idx, input logic down);
        goTo(at_edge);
        pressed[idx] = down;
    endtask

    task automatic pushExpected(input logic [3:0] k, input logic s, input int e);
        exp_q.push_back('{key: k, strobe: s, at_edge: e});
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence; edge numbers are hand-computed from the scan schedule.
    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_row", row, 4'b1110);
        checkOutput("reset_key", key, 4'd10);
        checkOutput("reset_strobe", {3'b000, key_strobe}, 4'd0);
        reset = 1'b1;

        // Idle scanning for 10 rotations: row steps every 16 clocks.
        for (int j = 0; j < 40; j++) begin
            goTo(16 * j + 8);
            exp_row = 4'b0001 << (j % 4);
            exp_row = ~exp_row;
            checkOutput("idle_row", row, exp_row);
        end

        // Hold 5: first valid sample at edge 672, key valid at 672+49-1 = 720.
        applyStimulus(645, K5, 1'b1);
        pushExpected(4'd5, 1'b1, 720);
        goTo(700);
        checkOutput("debounce5_row", row, 4'b1101);
        goTo(760);
        checkOutput("held5_row", row, 4'b1101);
        checkOutput("held5_key", key, 4'd5);

        // Release 5: first none sample at 816, key back to 10 at 864, next row r2.
        applyStimulus(800, K5, 1'b0);
        pushExpected(4'd10, 1'b0, 864);
        goTo(870);
        checkOutput("resume_row", row, 4'b1011);

        // Bounce 8: valid at 944/960/976, none at 992, no strobe expected.
        applyStimulus(900, K8, 1'b1);
        goTo(970);
        checkOutput("bounce8_key", key, 4'd10);
        checkOutput("bounce8_row", row, 4'b1011);
        applyStimulus(980, K8, 1'b0);
        // Stable 8: row2 sampled again at 1056, key at 1104; release gives 10 at 1184.
        applyStimulus(1000, K8, 1'b1);
        pushExpected(4'd8, 1'b1, 1104);
        applyStimulus(1120, K8, 1'b0);
        pushExpected(4'd10, 1'b0, 1184);

        // Non-digits and a two-column press never start a debounce.
        applyStimulus(1190, KSTAR, 1'b1);
        goTo(1208);
        checkOutput("star_row", row, 4'b1110);
        applyStimulus(1210, KSTAR, 1'b0);
        applyStimulus(1210, KHASH, 1'b1);
        goTo(1272);
        checkOutput("hash_row", row, 4'b1110);
        applyStimulus(1275, KHASH, 1'b0);
        applyStimulus(1275, K1, 1'b1);
        applyStimulus(1275, K2, 1'b1);
        goTo(1288);
        checkOutput("double_row", row, 4'b1101);
        checkOutput("double_key", key, 4'd10);
        applyStimulus(1290, K1, 1'b0);
        applyStimulus(1290, K2, 1'b0);

        // Hold 0 (sampled at 1328, key at 1376), press 3 meanwhile, then release 0.
        applyStimulus(1300, K0, 1'b1);
        pushExpected(4'd0, 1'b1, 1376);
        applyStimulus(1390, K3, 1'b1);
        goTo(1420);
        checkOutput("held0_row", row, 4'b0111);
        checkOutput("held0_key", key, 4'd0);
        applyStimulus(1430, K0, 1'b0);
        pushExpected(4'd10, 1'b0, 1488);
        pushExpected(4'd3, 1'b1, 1552);
        applyStimulus(1570, K3, 1'b0);
        pushExpected(4'd10, 1'b0, 1632);

        // Hold 0 again, then assert reset mid-operation.
        applyStimulus(1640, K0, 1'b1);
        pushExpected(4'd0, 1'b1, 1728);
        goTo(1760);
        #2 reset = 1'b0;
        #1;
        checkOutput("midreset_key", key, 4'd10);
        checkOutput("midreset_row", row, 4'b1110);
        checkOutput("midreset_strobe", {3'b000, key_strobe}, 4'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // 0 still held after reset: row3 sampled at edge 64, key at 112, no strobe before.
        pushExpected(4'd0, 1'b1, 112);
        goTo(60);
        checkOutput("postreset_key", key, 4'd10);
        applyStimulus(130, K0, 1'b0);
        pushExpected(4'd10, 1'b0, 192);
        goTo(230);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_events: %0d expected events never seen, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
